// File: rtl/echo_indication_deser.sv
`default_nettype none
// ============================================================================
// Module      : echo_indication_deser
// Description : Reassembles 32-bit portal FIFO words into one 96-bit Echo
//               indication message {v, meth, tag}.
//               Word 0 is a header {len[31:16], tag[15:0]}, followed by len
//               payload words. The first MAX_PAYLOAD payload words are kept.
//               Any further payload words are discarded and counted.
//               The assembled message is held on pipe_enq until it is
//               accepted.
// Ports       : CLK, nRST          clock, synchronous active-low reset
//               in_enq__ENA/RDY    word handshake into this block
//               in_enq_v[31:0]     word data
//               pipe_enq__ENA/RDY  message handshake out of this block
//               pipe_enq_v[95:0]   {payload1, payload0, 16'b0, tag}
//               drop_count[15:0]   saturating count of discarded payload words
//               abort_count[15:0]  saturating count of timed-out messages
// Config      : define ECHO_DESER_TIMEOUT_EN to abandon a message that sits
//               idle for TIMEOUT cycles in PAY/DRAIN. When it is undefined,
//               abort_count is tied to 0 and TIMEOUT is unused.
// Revision    : 1.0  initial release
// ============================================================================
module echo_indication_deser #(
  parameter int MAX_PAYLOAD = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_enq__ENA,
  input  logic [31:0] in_enq_v,
  output logic        in_enq__RDY,
  output logic        pipe_enq__ENA,
  output logic [95:0] pipe_enq_v,
  input  logic        pipe_enq__RDY,
  output logic [15:0] drop_count,
  output logic [15:0] abort_count
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PAY   = 2'd1,
    DRAIN = 2'd2,
    SEND  = 2'd3
  } state_t;

  // Slot index of the last kept payload word.
  localparam logic [1:0] LAST_IDX = 2'(MAX_PAYLOAD - 1);

  state_t      state;
  logic [15:0] tag;
  logic [15:0] remaining;
  logic [1:0]  idx;
  logic [31:0] payload0;
  logic [31:0] payload1;

  logic        word_acc;
  logic        msg_acc;
  logic [15:0] rem_next;

  assign in_enq__RDY   = nRST & (state != SEND);
  assign pipe_enq__ENA = nRST & (state == SEND);
  assign pipe_enq_v    = {payload1, payload0, 16'b0, tag};

  assign word_acc = in_enq__ENA & in_enq__RDY;
  assign msg_acc  = pipe_enq__ENA & pipe_enq__RDY;
  assign rem_next = remaining - 16'd1;

`ifdef ECHO_DESER_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] idle_cnt;
  logic [15:0] abort_cnt;
  assign abort_count = abort_cnt;
`else
  assign abort_count = 16'd0;
  logic unused_cfg;
  assign unused_cfg = ^{1'b0, 32'(TIMEOUT)};
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= HDR;
      tag        <= 16'd0;
      remaining  <= 16'd0;
      idx        <= 2'd0;
      payload0   <= 32'd0;
      payload1   <= 32'd0;
      drop_count <= 16'd0;
`ifdef ECHO_DESER_TIMEOUT_EN
      idle_cnt   <= 16'd0;
      abort_cnt  <= 16'd0;
`endif
    end else begin
      case (state)
        HDR: begin
          if (word_acc) begin
            tag       <= in_enq_v[15:0];
            remaining <= in_enq_v[31:16];
            idx       <= 2'd0;
            payload0  <= 32'd0;
            payload1  <= 32'd0;
            state     <= (in_enq_v[31:16] == 16'd0) ? SEND : PAY;
          end
        end
        PAY: begin
          if (word_acc) begin
            if (idx == 2'd0) payload0 <= in_enq_v;
            else             payload1 <= in_enq_v;
            idx       <= idx + 2'd1;
            remaining <= rem_next;
            if (rem_next == 16'd0)    state <= SEND;
            else if (idx == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (word_acc) begin
            remaining <= rem_next;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (rem_next == 16'd0) state <= SEND;
          end
        end
        SEND: begin
          if (msg_acc) state <= HDR;
        end
        default: state <= HDR;
      endcase

`ifdef ECHO_DESER_TIMEOUT_EN
      // Idle cycles are counted only while a message is in progress. The
      // timeout branch comes last, so it overrides the state update above.
      if ((state == PAY || state == DRAIN) && !word_acc) begin
        if (idle_cnt == IDLE_LIMIT) begin
          state    <= HDR;
          idle_cnt <= 16'd0;
          if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end else begin
        idle_cnt <= 16'd0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_indication_deser
// Description : Directed, self-checking bench for echo_indication_deser.
//               Inputs are driven 1 time unit after each rising edge, and
//               outputs are sampled at the same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_echo_indication_deser;

`ifdef ECHO_DESER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_ena;
  logic [31:0] in_v;
  logic        in_rdy;
  logic        pipe_ena;
  logic [95:0] pipe_v;
  logic        pipe_rdy;
  logic [15:0] drop_count;
  logic [15:0] abort_count;

  int compared   = 0;
  int mismatched = 0;

  echo_indication_deser #(.MAX_PAYLOAD(2), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK          (clk),
    .nRST         (n_rst),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .pipe_enq__ENA(pipe_ena),
    .pipe_enq_v   (pipe_v),
    .pipe_enq__RDY(pipe_rdy),
    .drop_count   (drop_count),
    .abort_count  (abort_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word for exactly one cycle. Back-to-back calls keep ENA high.
  task automatic put_word(input logic [31:0] w);
    in_ena = 1'b1;
    in_v   = w;
    tick();
    in_ena = 1'b0;
  endtask

  logic [95:0] held;

  initial begin
    n_rst    = 1'b0;
    in_ena   = 1'b0;
    in_v     = 32'd0;
    pipe_rdy = 1'b1;

    // Reset state
    tick(); tick();
    check_eq("rst_in_rdy", {95'd0, in_rdy}, 96'd0);
    check_eq("rst_pipe_ena", {95'd0, pipe_ena}, 96'd0);
    check_eq("rst_drop", {80'd0, drop_count}, 96'd0);
    check_eq("rst_abort", {80'd0, abort_count}, 96'd0);
    check_eq("rst_v", pipe_v, 96'd0);
    n_rst = 1'b1;
    #1;
    check_eq("post_rst_in_rdy", {95'd0, in_rdy}, 96'd1);

    // 1: basic 2-payload message
    put_word(32'h0002_0001);
    put_word(32'h0000_0005);
    check_eq("t1_no_ena_early", {95'd0, pipe_ena}, 96'd0);
    put_word(32'h0000_0009);
    check_eq("t1_ena", {95'd0, pipe_ena}, 96'd1);
    check_eq("t1_v", pipe_v, 96'h00000009_00000005_00000001);
    check_eq("t1_in_rdy_send", {95'd0, in_rdy}, 96'd0);
    tick();
    check_eq("t1_in_rdy_after", {95'd0, in_rdy}, 96'd1);
    check_eq("t1_ena_after", {95'd0, pipe_ena}, 96'd0);

    // 2: downstream back-pressure for 10 cycles
    pipe_rdy = 1'b0;
    put_word(32'h0002_0001);
    put_word(32'h0000_0005);
    put_word(32'h0000_0009);
    held = 96'h00000009_00000005_00000001;
    for (int i = 0; i < 10; i++) begin
      check_eq("t2_ena_held", {95'd0, pipe_ena}, 96'd1);
      check_eq("t2_v_stable", pipe_v, held);
      check_eq("t2_in_rdy_low", {95'd0, in_rdy}, 96'd0);
      tick();
    end
    pipe_rdy = 1'b1;
    #1;
    check_eq("t2_ena_at_rdy", {95'd0, pipe_ena}, 96'd1);
    tick();
    check_eq("t2_ena_done", {95'd0, pipe_ena}, 96'd0);
    check_eq("t2_in_rdy_done", {95'd0, in_rdy}, 96'd1);

    // 3: oversize message, two payload words dropped
    put_word(32'h0004_0003);
    put_word(32'hAAAA_0001);
    put_word(32'hBBBB_0002);
    put_word(32'hCCCC_0003);
    check_eq("t3_no_ena_draining", {95'd0, pipe_ena}, 96'd0);
    put_word(32'hDDDD_0004);
    check_eq("t3_ena", {95'd0, pipe_ena}, 96'd1);
    check_eq("t3_v", pipe_v, 96'hBBBB0002_AAAA0001_00000003);
    check_eq("t3_drop", {80'd0, drop_count}, 96'd2);
    tick();

    // 4: header only (len 0). Also shows the next header after a drain is taken normally.
    put_word(32'h0000_0007);
    check_eq("t4_ena", {95'd0, pipe_ena}, 96'd1);
    check_eq("t4_v", pipe_v, 96'h00000000_00000000_00000007);
    tick();

    // 5: reset in the middle of a message
    put_word(32'h0002_0001);
    put_word(32'h0000_0005);
    n_rst = 1'b0;
    #1;
    check_eq("t5_in_rdy_in_rst", {95'd0, in_rdy}, 96'd0);
    check_eq("t5_ena_in_rst", {95'd0, pipe_ena}, 96'd0);
    tick();
    n_rst = 1'b1;
    #1;
    check_eq("t5_ena_after_rst", {95'd0, pipe_ena}, 96'd0);
    check_eq("t5_drop_cleared", {80'd0, drop_count}, 96'd0);
    put_word(32'h0002_0011);
    put_word(32'h0000_0022);
    put_word(32'h0000_0033);
    check_eq("t5_ena", {95'd0, pipe_ena}, 96'd1);
    check_eq("t5_v", pipe_v, 96'h00000033_00000022_00000011);
    tick();

`ifdef ECHO_DESER_TIMEOUT_EN
    // 6: message stalls for TIMEOUT idle cycles and is abandoned
    put_word(32'h0002_0001);
    put_word(32'h0000_0005);
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_no_ena", {95'd0, pipe_ena}, 96'd0);
      tick();
    end
    check_eq("t6_abort", {80'd0, abort_count}, 96'd1);
    check_eq("t6_in_rdy", {95'd0, in_rdy}, 96'd1);
    put_word(32'h0002_0044);
    put_word(32'h0000_0055);
    put_word(32'h0000_0066);
    check_eq("t6_ena", {95'd0, pipe_ena}, 96'd1);
    check_eq("t6_v", pipe_v, 96'h00000066_00000055_00000044);
    tick();
`else
    check_eq("abort_tied_zero", {80'd0, abort_count}, 96'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
